// File: rtl/d_phase_decoder.sv
// d_phase_decoder: checks that each sequencer start pulse walks q1..q5 legally.
// Ports: clk, reset (async low), q1..q5, clr_err -> phase, busy, done, err, err_code, seq_count.
module d_phase_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             q1,
  input  logic             q2,
  input  logic             q3,
  input  logic             q4,
  input  logic             q5,
  input  logic             clr_err,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] seq_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    S5   = 3'd5,
    ERR  = 3'd6
  } state_t;

  state_t           r_state;
  logic [2:0]       r_phase;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_code;
  logic [CNT_W-1:0] r_cnt;

  logic [4:0] w_v;
  logic [4:0] w_exp;
  logic       w_zero;
  logic       w_multi;
  logic       w_start;
  logic [1:0] w_bad;

  assign w_v     = {q5, q4, q3, q2, q1};
  assign w_zero  = (w_v == 5'b00000);
  // Clearing the lowest set bit leaves something only if 2+ bits are set.
  assign w_multi = ((w_v & (w_v - 5'd1)) != 5'b00000);
  assign w_start = (w_v == 5'b00001);
  // Error cause priority: multi-hot, then dropped, then wrong phase.
  assign w_bad   = w_multi ? 2'd1 : (w_zero ? 2'd3 : 2'd2);

  always_comb begin
    w_exp = 5'b00000;
    unique case (r_state)
      S1:      w_exp = 5'b00010;
      S2:      w_exp = 5'b00100;
      S3:      w_exp = 5'b01000;
      S4:      w_exp = 5'b10000;
      default: w_exp = 5'b00000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_phase <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_multi) begin
            r_state <= ERR;
            r_err   <= 1'b1;
            r_code  <= w_bad;
          end else if (w_start) begin
            r_state <= S1;
            r_phase <= 3'd1;
            r_busy  <= 1'b1;
          end
        end
        S1, S2, S3, S4: begin
          if (w_v == w_exp) begin
            r_state <= state_t'(r_state + 3'd1);
            r_phase <= r_phase + 3'd1;
            r_busy  <= (r_state != S4);
            if (r_state == S4) begin
              r_done <= 1'b1;
              r_cnt  <= r_cnt + CNT_W'(1);
            end
          end else begin
            r_state <= ERR;
            r_err   <= 1'b1;
            r_code  <= w_bad;
            r_phase <= 3'd0;
            r_busy  <= 1'b0;
          end
        end
        S5: begin
          if (w_zero) begin
            r_state <= IDLE;
            r_phase <= 3'd0;
          end else if (w_start) begin
            // back-to-back walk
            r_state <= S1;
            r_phase <= 3'd1;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ERR;
            r_err   <= 1'b1;
            r_code  <= w_bad;
            r_phase <= 3'd0;
          end
        end
        ERR: begin
          if (clr_err) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
            r_code  <= 2'd0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_phase <= 3'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign phase     = r_phase;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign err_code  = r_code;
  assign seq_count = r_cnt;

endmodule

// File: tb/tb_d_phase_decoder.sv
// tb_d_phase_decoder: scoreboard bench for d_phase_decoder.
// Stimulus pushes model expectations; a monitor pops and compares each cycle.
module tb_d_phase_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       q1, q2, q3, q4, q5;
  logic       clr_err;
  logic [2:0] phase;
  logic       busy, done, err;
  logic [1:0] err_code;
  logic [7:0] seq_count;

  d_phase_decoder #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5),
    .clr_err(clr_err),
    .phase(phase), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .seq_count(seq_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ph;
    logic       bsy;
    logic       dn;
    logic       er;
    logic [1:0] cd;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: last legal phase index, error flag/cause, walk count.
  int         m_p;
  bit         m_err;
  int         m_code;
  logic [7:0] m_cnt;

  task automatic m_reset();
    m_p = 0; m_err = 0; m_code = 0; m_cnt = 8'd0;
  endtask

  task automatic m_step(input logic [4:0] v, input bit clr, output exp_t e);
    int n;
    int idx;
    bit dn;
    int c;
    n = $countones(v);
    idx = 0;
    for (int i = 0; i < 5; i++) if (v[i]) idx = i + 1;
    dn = 0;
    c = 0;
    if (m_err) begin
      if (clr) begin m_err = 0; m_code = 0; m_p = 0; end
    end else if (m_p == 0) begin
      if (n > 1) c = 1;
      else if (n == 1 && idx == 1) m_p = 1;
    end else if (m_p < 5) begin
      if (n == 1 && idx == m_p + 1) begin
        m_p++;
        if (m_p == 5) begin dn = 1; m_cnt = m_cnt + 8'd1; end
      end else if (n > 1) c = 1;
      else if (n == 0) c = 3;
      else c = 2;
    end else begin
      if (n == 0) m_p = 0;
      else if (n == 1 && idx == 1) m_p = 1;
      else if (n > 1) c = 1;
      else c = 2;
    end
    if (c != 0) begin m_err = 1; m_code = c; m_p = 0; end
    e.ph  = 3'(m_p);
    e.bsy = (m_p >= 1 && m_p <= 4);
    e.dn  = dn;
    e.er  = m_err;
    e.cd  = 2'(m_code);
    e.cnt = m_cnt;
  endtask

  task automatic cyc(input logic [4:0] v, input bit clr = 0);
    exp_t e;
    @(negedge clk);
    {q5, q4, q3, q2, q1} = v;
    clr_err = clr;
    m_step(v, clr, e);
    sb.push_back(e);
  endtask

  task automatic walk();
    cyc(5'b00001); cyc(5'b00010); cyc(5'b00100);
    cyc(5'b01000); cyc(5'b10000);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Monitor: outputs are registered, so one sample per clock after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (phase !== e.ph || busy !== e.bsy || done !== e.dn ||
            err !== e.er || err_code !== e.cd || seq_count !== e.cnt) begin
          errors++;
          $display("FAIL cycle t=%0t: got ph=%0d bsy=%0b dn=%0b er=%0b cd=%0d cnt=%0d expected ph=%0d bsy=%0b dn=%0b er=%0b cd=%0d cnt=%0d",
                   $time, phase, busy, done, err, err_code, seq_count,
                   e.ph, e.bsy, e.dn, e.er, e.cd, e.cnt);
        end
      end
    end
  end

  initial begin
    int op;
    logic [4:0] rv;
    reset = 1'b0;
    {q5, q4, q3, q2, q1} = 5'b0;
    clr_err = 1'b0;
    m_reset();
    #12;
    chk("reset_phase", phase, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", err, 0);
    chk("reset_cnt", seq_count, 0);
    @(negedge clk);
    reset = 1'b1;

    // single walk
    walk();
    cyc(5'b0); cyc(5'b0);

    // back-to-back walks
    repeat (4) walk();
    cyc(5'b0);

    // start held two cycles: multi-hot, then first cause kept
    cyc(5'b00001); cyc(5'b00011); cyc(5'b00110);
    cyc(5'b01100); cyc(5'b11000); cyc(5'b10000);
    walk();
    cyc(5'b0, 1);

    // dropped in S3, then skipped in S1
    cyc(5'b00001); cyc(5'b00010); cyc(5'b00100); cyc(5'b00000);
    cyc(5'b0, 1);
    cyc(5'b00001); cyc(5'b01000);
    cyc(5'b0, 1);

    // clear while 00100 present, then residual phases ignored
    cyc(5'b00001); cyc(5'b00010); cyc(5'b00000);
    cyc(5'b00100, 1); cyc(5'b01000); cyc(5'b10000);
    walk();
    cyc(5'b0);

    // async reset mid-walk in S3
    cyc(5'b00001); cyc(5'b00010); cyc(5'b00100);
    @(posedge clk);
    #3;
    reset = 1'b0;
    {q5, q4, q3, q2, q1} = 5'b0;
    #1;
    chk("arst_phase", phase, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    chk("arst_code", err_code, 0);
    chk("arst_cnt", seq_count, 0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    cyc(5'b01000); cyc(5'b10000); cyc(5'b0);

    // 256 back-to-back walks wrap the counter through 255 -> 0
    repeat (256) walk();
    cyc(5'b0);

    // randomized traffic
    repeat (300) begin
      op = $urandom_range(0, 9);
      if (op < 4) walk();
      else if (op < 7) begin
        rv = 5'($urandom_range(0, 31));
        cyc(rv);
      end else if (op < 8) begin
        rv = 5'($urandom_range(0, 31));
        cyc(rv, 1);
      end else cyc(5'b0);
    end
    cyc(5'b0);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
